// File: rtl/kmeans_acc_pkg.sv
// Shared constants and types for the k-means centroid accumulator.
// Holds the default widths, the coordinate count per point, the
// accumulator FSM state type and the signed coordinate-sum type.
package kmeans_acc_pkg;

  localparam int unsigned NUM_CORDS        = 7;
  localparam int unsigned CENTROID_NUM     = 8;
  localparam int unsigned CORDINATE_WIDTH  = 13;
  localparam int unsigned ACCUM_CORD_WIDTH = 22;
  localparam int unsigned COUNT_WIDTH      = 10;
  localparam int unsigned DATA_WIDTH       = NUM_CORDS * CORDINATE_WIDTH;
  localparam int unsigned ACCUM_WIDTH      = NUM_CORDS * ACCUM_CORD_WIDTH;

  typedef enum logic [1:0] {
    S_ACCUM,
    S_DRAIN,
    S_CLEAR
  } acc_state_t;

  typedef logic signed [ACCUM_CORD_WIDTH-1:0] acc_cord_t;

endpackage

// File: rtl/centroid_accumulator_if.sv
// Point-input and centroid-output streams of the centroid accumulator.
//   point_*      : upstream classified points (valid/ready)
//   out_*, accumulator, counter : per-centroid drain stream (valid/ready)
// slave  : the accumulator side
// master : the environment side (point source and drain sink)
interface centroid_accumulator_if
  import kmeans_acc_pkg::*;
#(
  parameter int unsigned centroid_num = CENTROID_NUM,
  parameter int unsigned count_width  = COUNT_WIDTH,
  parameter int unsigned dataWidth    = DATA_WIDTH,
  parameter int unsigned accum_width  = ACCUM_WIDTH
);

  logic                            point_valid;
  logic                            point_ready;
  logic [dataWidth-1:0]            point_data;
  logic [$clog2(centroid_num)-1:0] point_cent_idx;

  logic                            out_valid;
  logic                            out_ready;
  logic [$clog2(centroid_num)-1:0] out_cent_idx;
  logic [accum_width-1:0]          accumulator;
  logic [count_width-1:0]          counter;

  modport slave (
    input  point_valid, point_data, point_cent_idx, out_ready,
    output point_ready, out_valid, out_cent_idx, accumulator, counter
  );

  modport master (
    output point_valid, point_data, point_cent_idx, out_ready,
    input  point_ready, out_valid, out_cent_idx, accumulator, counter
  );

endinterface

// File: rtl/centroid_accum_entry.sv
// One bank row: seven signed coordinate sums and a point counter.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous row clear
//   en        : add point_data into this row this cycle
//   sums      : packed sums, coordinate 1 in the LSBs
//   count     : number of points accumulated
//   accum_ovf : this cycle's add overflowed some coordinate (signed)
//   count_ovf : this cycle's point was dropped, counter saturated
module centroid_accum_entry
  import kmeans_acc_pkg::*;
#(
  parameter int unsigned cordinate_width  = CORDINATE_WIDTH,
  parameter int unsigned accum_cord_width = ACCUM_CORD_WIDTH,
  parameter int unsigned count_width      = COUNT_WIDTH,
  parameter int unsigned dataWidth        = DATA_WIDTH,
  parameter int unsigned accum_width      = ACCUM_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [dataWidth-1:0]   point_data,
  output logic [accum_width-1:0] sums,
  output logic [count_width-1:0] count,
  output logic                   accum_ovf,
  output logic                   count_ovf
);

  localparam int unsigned Msb = accum_cord_width - 1;
  localparam int unsigned ExtBits = accum_cord_width - cordinate_width;

  logic signed [accum_cord_width-1:0] sum_q [NUM_CORDS];
  logic signed [accum_cord_width-1:0] sum_d [NUM_CORDS];
  logic signed [accum_cord_width-1:0] ext   [NUM_CORDS];
  logic [count_width-1:0]             count_q;
  logic                               sat;
  logic                               add;
  logic                               ovf_any;

  assign sat = &count_q;
  // A saturated row drops the whole point, sums included.
  assign add = en && !sat;

  always_comb begin
    ovf_any = 1'b0;
    for (int k = 0; k < NUM_CORDS; k++) begin
      ext[k] = {{ExtBits{point_data[k*cordinate_width + cordinate_width - 1]}},
                point_data[k*cordinate_width +: cordinate_width]};
      sum_d[k] = sum_q[k] + ext[k];
      if ((sum_q[k][Msb] == ext[k][Msb]) && (sum_d[k][Msb] != sum_q[k][Msb])) begin
        ovf_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < NUM_CORDS; k++) sum_q[k] <= '0;
      count_q <= '0;
    end else if (add) begin
      for (int k = 0; k < NUM_CORDS; k++) sum_q[k] <= sum_d[k];
      count_q <= count_q + count_width'(1);
    end
  end

  always_comb begin
    sums = '0;
    for (int k = 0; k < NUM_CORDS; k++) sums[k*accum_cord_width +: accum_cord_width] = sum_q[k];
  end

  assign count     = count_q;
  assign accum_ovf = add && ovf_any;
  assign count_ovf = en && sat;

endmodule

// File: rtl/centroid_accumulator.sv
// Per-centroid sum/count bank for the k-means centroid update.
// Accumulates classified points, then drains one centroid per handshake
// in the packed format of the downstream divider, then clears the bank.
//   clk, rst        : clock, synchronous active-high reset
//   clear           : synchronous bank/flag clear, FSM back to S_ACCUM
//   start_drain     : pulse, begins readout (honoured in S_ACCUM only)
//   bus             : point input and centroid output streams
//   drain_done      : pulse in the cycle after the last centroid is taken
//   accum_overflow  : sticky, some coordinate sum overflowed
//   count_overflow  : sticky, a point was dropped on a saturated counter
module centroid_accumulator
  import kmeans_acc_pkg::*;
#(
  parameter int unsigned centroid_num     = CENTROID_NUM,
  parameter int unsigned cordinate_width  = CORDINATE_WIDTH,
  parameter int unsigned accum_cord_width = ACCUM_CORD_WIDTH,
  parameter int unsigned count_width      = COUNT_WIDTH,
  parameter int unsigned dataWidth        = DATA_WIDTH,
  parameter int unsigned accum_width      = ACCUM_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   start_drain,
  centroid_accumulator_if.slave  bus,
  output logic                   drain_done,
  output logic                   accum_overflow,
  output logic                   count_overflow
);

  localparam int unsigned IdxWidth = $clog2(centroid_num);

  acc_state_t            state_q, state_d;
  logic [IdxWidth-1:0]   ptr_q, ptr_d;
  logic                  accept;
  logic                  idx_ok;
  logic                  bank_clr;
  logic                  accum_ovf_q, count_ovf_q;
  logic [centroid_num-1:0] row_en;
  logic [centroid_num-1:0] row_accum_ovf;
  logic [centroid_num-1:0] row_count_ovf;
  logic [accum_width-1:0]  row_sums  [centroid_num];
  logic [count_width-1:0]  row_count [centroid_num];

  assign accept   = bus.point_valid && bus.point_ready;
  // Out-of-range indices are silently dropped.
  assign idx_ok   = 32'(bus.point_cent_idx) < centroid_num;
  assign bank_clr = clear || (state_q == S_CLEAR);

  for (genvar i = 0; i < centroid_num; i++) begin : g_row
    assign row_en[i] = accept && idx_ok && (bus.point_cent_idx == IdxWidth'(i));

    centroid_accum_entry #(
      .cordinate_width (cordinate_width),
      .accum_cord_width(accum_cord_width),
      .count_width     (count_width),
      .dataWidth       (dataWidth),
      .accum_width     (accum_width)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .clr       (bank_clr),
      .en        (row_en[i]),
      .point_data(bus.point_data),
      .sums      (row_sums[i]),
      .count     (row_count[i]),
      .accum_ovf (row_accum_ovf[i]),
      .count_ovf (row_count_ovf[i])
    );
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_ACCUM: begin
        if (start_drain) begin
          state_d = S_DRAIN;
          ptr_d   = '0;
        end
      end
      S_DRAIN: begin
        if (bus.out_ready) begin
          if (ptr_q == IdxWidth'(centroid_num - 1)) state_d = S_CLEAR;
          else ptr_d = ptr_q + 1'b1;
        end
      end
      S_CLEAR: state_d = S_ACCUM;
      default: state_d = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= S_ACCUM;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      accum_ovf_q <= 1'b0;
      count_ovf_q <= 1'b0;
    end else begin
      if (|row_accum_ovf) accum_ovf_q <= 1'b1;
      if (|row_count_ovf) count_ovf_q <= 1'b1;
    end
  end

  assign bus.point_ready  = (state_q == S_ACCUM);
  assign bus.out_valid    = (state_q == S_DRAIN);
  assign bus.out_cent_idx = ptr_q;
  assign bus.accumulator  = row_sums[ptr_q];
  assign bus.counter      = row_count[ptr_q];
  assign drain_done       = (state_q == S_CLEAR);
  assign accum_overflow   = accum_ovf_q;
  assign count_overflow   = count_ovf_q;

endmodule

// File: tb/tb_centroid_accumulator.sv
// Scoreboard bench: drains push hand-computed per-centroid expectations,
// a monitor compares every presented centroid against the queue head.
module tb_centroid_accumulator;
  import kmeans_acc_pkg::*;

  logic clk = 1'b0;
  logic rst, clear, start_drain;
  logic drain_done, accum_overflow, count_overflow;

  always #5 clk = ~clk;

  centroid_accumulator_if bus ();

  centroid_accumulator dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .start_drain   (start_drain),
    .bus           (bus),
    .drain_done    (drain_done),
    .accum_overflow(accum_overflow),
    .count_overflow(count_overflow)
  );

  typedef struct {
    logic [2:0]             idx;
    logic [ACCUM_WIDTH-1:0] acc;
    logic [9:0]             cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  int   hs_cnt   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [ACCUM_WIDTH-1:0] rep_sum(input logic [21:0] v);
    return {7{v}};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rep_pt(input logic [12:0] v);
    return {7{v}};
  endfunction

  // Expect all eight centroids; only 'hot' carries data.
  task automatic push_bank(input int hot, input logic [ACCUM_WIDTH-1:0] acc, input logic [9:0] cnt);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.idx = 3'(i);
      e.acc = (i == hot) ? acc : '0;
      e.cnt = (i == hot) ? cnt : 10'd0;
      q.push_back(e);
    end
  endtask

  task automatic put_point(input logic [2:0] idx, input logic [DATA_WIDTH-1:0] data);
    bus.point_valid    = 1'b1;
    bus.point_cent_idx = idx;
    bus.point_data     = data;
    @(posedge clk); #1;
    bus.point_valid    = 1'b0;
  endtask

  // Pulses start_drain (any point already driven goes in the same cycle),
  // then runs the drain with out_ready high or toggling 1,0,0,1.
  task automatic run_drain(input bit stall);
    int d0 = done_cnt;
    int h0 = hs_cnt;
    bit ok = 1'b0;
    start_drain = 1'b1;
    @(posedge clk); #1;
    start_drain     = 1'b0;
    bus.point_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      bus.out_ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      @(posedge clk); #1;
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    bus.out_ready = 1'b1;
    check("drain_done_seen", ok, 1);
    check("drain_done_once", done_cnt - d0, 1);
    check("handshake_count", hs_cnt - h0, 8);
    check("queue_drained", q.size(), 0);
    check("ready_after_drain", bus.point_ready, 1);
  endtask

  // Monitor: every presented centroid must match the queue head, which
  // also proves the outputs hold through stalls.
  initial begin
    exp_t e;
    bit   last_final = 1'b0;
    forever begin
      @(negedge clk);
      if (drain_done === 1'b1) begin
        done_cnt++;
        check("done_after_last_hs", last_final, 1);
      end
      last_final = 1'b0;
      if (bus.out_valid === 1'b1) begin
        check("point_ready_low_in_drain", bus.point_ready, 0);
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got idx %0d expected no output", bus.out_cent_idx);
        end else begin
          e = q[0];
          check("out_cent_idx", bus.out_cent_idx, e.idx);
          check("accumulator", bus.accumulator, e.acc);
          check("counter", bus.counter, e.cnt);
          if (bus.out_ready === 1'b1) begin
            void'(q.pop_front());
            hs_cnt++;
            last_final = (e.idx == 3'd7);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    rst = 1'b1; clear = 1'b0; start_drain = 1'b0;
    bus.point_valid = 1'b0; bus.point_cent_idx = '0; bus.point_data = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_point_ready", bus.point_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_drain_done", drain_done, 0);
    check("rst_accum_ovf", accum_overflow, 0);
    check("rst_count_ovf", count_overflow, 0);
    check("rst_accumulator", bus.accumulator, 0);
    check("rst_counter", bus.counter, 0);

    // Three +5 points to centroid 2, then a drain of an empty bank.
    repeat (3) put_point(3'd2, rep_pt(13'd5));
    push_bank(2, rep_sum(22'd15), 10'd3);
    run_drain(1'b0);
    push_bank(-1, '0, 10'd0);
    run_drain(1'b0);

    // Sign extension: -4096 + 4095 = -1.
    put_point(3'd0, rep_pt(13'h1000));
    put_point(3'd0, rep_pt(13'h0FFF));
    check("no_accum_ovf_small", accum_overflow, 0);
    check("no_count_ovf_small", count_overflow, 0);
    push_bank(0, rep_sum(22'h3FFFFF), 10'd2);
    run_drain(1'b0);

    // Counter saturation and sum wrap: 1023*4095 = 22'h3FEC01 modulo 2^22.
    repeat (1023) put_point(3'd7, rep_pt(13'h0FFF));
    check("count_ovf_at_1023", count_overflow, 0);
    check("accum_ovf_set", accum_overflow, 1);
    put_point(3'd7, rep_pt(13'h0FFF));
    check("count_ovf_at_1024", count_overflow, 1);
    push_bank(7, rep_sum(22'h3FEC01), 10'd1023);
    run_drain(1'b0);
    check("accum_ovf_persists", accum_overflow, 1);
    check("count_ovf_persists", count_overflow, 1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear_accum_ovf", accum_overflow, 0);
    check("clear_count_ovf", count_overflow, 0);

    // Point in the start_drain cycle, distinct coordinates, stalled drain.
    push_bank(1, {22'd7, 22'd6, 22'd5, 22'd4, 22'd3, 22'd2, 22'd1}, 10'd1);
    bus.point_valid    = 1'b1;
    bus.point_cent_idx = 3'd1;
    bus.point_data     = {13'd7, 13'd6, 13'd5, 13'd4, 13'd3, 13'd2, 13'd1};
    run_drain(1'b1);

    // Reset at the 4th handshake of a drain.
    repeat (513) put_point(3'd5, rep_pt(13'h0FFF));
    check("accum_ovf_before_rst", accum_overflow, 1);
    push_bank(-1, '0, 10'd0);
    start_drain = 1'b1;
    @(posedge clk); #1;
    start_drain = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_cent_idx == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_found_idx3", found, 1);
    check("rst_mid_handshakes", q.size(), 4);
    q.delete();
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_point_ready", bus.point_ready, 1);
    check("rst_mid_drain_done", drain_done, 0);
    check("rst_mid_accum_ovf", accum_overflow, 0);
    check("rst_mid_count_ovf", count_overflow, 0);
    check("rst_mid_out_cent_idx", bus.out_cent_idx, 0);
    check("rst_mid_accumulator", bus.accumulator, 0);
    check("rst_mid_counter", bus.counter, 0);

    put_point(3'd4, rep_pt(13'd5));
    push_bank(4, rep_sum(22'd5), 10'd1);
    run_drain(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/centroid_accumulator.md
Name: centroid_accumulator

Overview:
- Stage directly upstream of parsing_dividing in the k-means centroid-update path.
- Each classified point carries 7 signed coordinates and the index of its nearest centroid. The block adds the point into that centroid's per-coordinate sums and increments that centroid's point count.
- On request, it drains the per-centroid sums and counts one centroid at a time, in the packed format the divider consumes: accumulator [7*22-1:0] with coordinate 1 in the LSBs, plus counter [9:0].
- After the drain it clears itself for the next iteration.

Parameters:
- centroid_num, 8: number of centroids (bank depth).
- cordinate_width, 13: width of one signed input coordinate.
- accum_cord_width, 22: width of one signed coordinate sum.
- count_width, 10: width of the per-centroid point counter.
- dataWidth, 91: width of the packed input point (7*cordinate_width).
- accum_width, 154: width of the packed output sums (7*accum_cord_width).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous bank clear; returns the FSM to S_ACCUM.
- point_valid  in  1  an input point is present.
- point_ready  out  1  block can accept a point; high only in S_ACCUM.
- point_data  in  dataWidth  7 packed two's-complement coordinates; coordinate 1 in the LSBs.
- point_cent_idx  in  $clog2(centroid_num)  target centroid of the point.
- start_drain  in  1  one-cycle pulse; begins readout.
- out_valid  out  1  accumulator/counter/out_cent_idx are valid.
- out_ready  in  1  downstream accepts the current centroid.
- out_cent_idx  out  $clog2(centroid_num)  centroid being presented.
- accumulator  out  accum_width  packed sums for out_cent_idx; feeds parsing_dividing.accumulator.
- counter  out  count_width  point count for out_cent_idx; feeds parsing_dividing.counter.
- drain_done  out  1  one-cycle pulse after the last centroid is accepted.
- accum_overflow  out  1  sticky flag: some coordinate sum had a signed overflow.
- count_overflow  out  1  sticky flag: a point was dropped because its counter was saturated.

Behaviour:
- Reset (rst=1 at a clock edge):
  - all sums and counts become 0; state becomes S_ACCUM; drain pointer becomes 0.
  - out_valid=0, drain_done=0, both overflow flags=0, point_ready=1 on the cycle after reset.
  - rst has priority over every other input, including mid-drain.
- clear: same effect as rst, but only after rst. It also clears the overflow flags.
- States:
  - S_ACCUM: accepts points; point_ready=1, out_valid=0.
  - S_DRAIN: presents centroids; point_ready=0, out_valid=1.
  - S_CLEAR: one cycle; zeroes the bank and pulses drain_done; point_ready=0, out_valid=0.
- Transitions:
  - S_ACCUM -> S_DRAIN on start_drain, with the drain pointer set to 0.
  - S_DRAIN -> S_CLEAR when out_valid && out_ready && pointer==centroid_num-1.
  - S_CLEAR -> S_ACCUM unconditionally.
  - start_drain outside S_ACCUM is ignored.
- Accumulate: a point is accepted when point_valid && point_ready at an edge.
  - Each coordinate is sign-extended from 13 to 22 bits and added to bank[idx].coord[k].
  - bank[idx].count increments by 1.
  - Results are visible from the next cycle (1-cycle latency). Throughput is 1 point per cycle.
- Counter saturation: if bank[idx].count == 2^count_width-1, the point is dropped entirely (sums untouched) and count_overflow is set.
- Sum overflow: sums wrap modulo 2^22. A signed overflow on any coordinate (operand signs equal, result sign differs) sets accum_overflow.
- point_cent_idx >= centroid_num: point dropped, no flag, point_ready unaffected.
- start_drain and an accepted point in the same cycle: the point is accumulated; the drain starts next cycle and includes that point.
- Drain:
  - accumulator, counter and out_cent_idx are a combinational mux of bank[pointer]. They are stable while out_valid && !out_ready.
  - The pointer advances on each handshake.
  - With out_ready held high, 8 consecutive out_valid cycles occur; drain_done pulses the cycle after the 8th handshake.
- Zero-count centroids are still presented with counter=0. parsing_dividing flags divide-by-0 and downstream handles it.
- Overflow flags persist across drains; only rst or clear clears them.

Decomposition:
- Package kmeans_acc_pkg holds:
  - localparam NUM_CORDS=7.
  - the default widths above.
  - typedef enum {S_ACCUM, S_DRAIN, S_CLEAR} acc_state_t.
  - typedef logic signed [accum_cord_width-1:0] acc_cord_t.
- Sub-module centroid_accum_entry: one bank row.
  - Contents: 7 sum registers, a count register, enable-gated add with sign extension, saturation check, per-row overflow output.
  - Instantiated centroid_num times with a generate loop.
  - The top level holds the FSM, drain pointer, output mux and sticky flags.

Test Plan:
- Reset, then 3 points to centroid 2, each with all coordinates = +5, then start_drain with out_ready=1:
  - idx 2 shows every coordinate = 15 and counter=3.
  - all other indices show 0 and counter=0.
  - drain_done pulses once; the bank reads 0 afterwards.
- Coordinates -4096 (0x1000) and +4095 to centroid 0: sum coordinate = -1 (22'h3FFFFF), which confirms sign extension.
- 1024 points of +4095 to centroid 7:
  - the 1024th is dropped; count=1023 and count_overflow=1.
  - accum_overflow=1, because 1023*4095 exceeds the 22-bit signed range.
- start_drain in the same cycle as a point to centroid 1: the drained idx 1 includes that point, with counter=1.
- out_ready toggling 1,0,0,1 during the drain: outputs hold on stall cycles; exactly 8 handshakes in idx order 0..7; point_ready=0 throughout.
- rst asserted at the 4th drain handshake:
  - next cycle is S_ACCUM with all outputs at reset values, bank zero, flags 0.
  - a following point accumulates normally.
